// File: rtl/enemy_chaser_pkg.sv
// Shared types and helpers for the boxhead enemy controller: life-cycle states,
// facing directions, playfield bounds and the clamped single-axis step.
package enemy_pkg;

   typedef enum logic [2:0] {
      DEAD   = 3'd0,
      SPAWN  = 3'd1,
      CHASE  = 3'd2,
      ATTACK = 3'd3,
      DYING  = 3'd4
   } enemy_state_t;

   typedef enum logic [1:0] {
      DOWN  = 2'd0,
      LEFT  = 2'd1,
      UP    = 2'd2,
      RIGHT = 2'd3
   } dir_t;

   localparam int PF_X_MIN = 0;
   localparam int PF_X_MAX = 319;
   localparam int PF_Y_MIN = 52;
   localparam int PF_Y_MAX = 205;

   // One optional step on an axis, then the result is forced into [lo, hi].
   // Worked at 10 bits so neither the add nor the subtract can wrap.
   function automatic logic [8:0] move_clamp(
      input logic [8:0] pos,
      input logic       inc,
      input logic       dec,
      input logic [8:0] step,
      input logic [8:0] lo,
      input logic [8:0] hi
   );
      logic [9:0] p;
      p = {1'b0, pos};
      if (inc)
         p = p + {1'b0, step};
      else if (dec)
         p = (p < ({1'b0, lo} + {1'b0, step})) ? {1'b0, lo} : p - {1'b0, step};
      if (p < {1'b0, lo})
         p = {1'b0, lo};
      else if (p > {1'b0, hi})
         p = {1'b0, hi};
      return p[8:0];
   endfunction

endpackage

// File: rtl/enemy_chaser_if.sv
// Game-facing bundle of one enemy: spawn/hit strobes, draw pixel and player
// position in; sprite position, ROM address and damage strobe out.
interface enemy_chaser_if;
   logic        spawn_req;
   logic        hit;
   logic [8:0]  PixelX;
   logic [8:0]  PixelY;
   logic [8:0]  Player_X;
   logic [8:0]  Player_Y;
   logic        is_obj;
   logic [12:0] Obj_address;
   logic [8:0]  Obj_X_Pos;
   logic [8:0]  Obj_Y_Pos;
   logic [1:0]  Obj_Direction;
   logic        Attack_Strobe;
   logic        is_alive;

   modport master (
      output spawn_req, hit, PixelX, PixelY, Player_X, Player_Y,
      input  is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction,
             Attack_Strobe, is_alive
   );

   modport slave (
      input  spawn_req, hit, PixelX, PixelY, Player_X, Player_Y,
      output is_obj, Obj_address, Obj_X_Pos, Obj_Y_Pos, Obj_Direction,
             Attack_Strobe, is_alive
   );
endinterface

// File: rtl/enemy_tick_gen.sv
// Move-tick generator: synchronises the asynchronous frame_clk level, detects
// its rising edges and emits a one-cycle tick every FRAME_DIV edges.
module enemy_tick_gen #(
   parameter int FRAME_DIV = 4
) (
   input  logic Clk,
   input  logic Reset,
   input  logic frame_clk,
   output logic tick
);
   // sync[0] may go metastable, sync[1] is the clean level, sync[2] its history.
   logic [2:0] sync;
   logic [3:0] div_cnt;
   logic       rise;

   assign rise = sync[1] & ~sync[2];

   // NOTE: non-blocking for every flop so each samples values from before the edge.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         sync    <= '0;
         div_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         sync <= {sync[1:0], frame_clk};
         tick <= 1'b0;
         if (rise) begin
            if (div_cnt == 4'(FRAME_DIV - 1)) begin
               div_cnt <= '0;
               tick    <= 1'b1;
            end else begin
               div_cnt <= div_cnt + 4'd1;
            end
         end
      end
   end
endmodule

// File: rtl/enemy_chaser.sv
// One boxhead enemy: life-cycle FSM, chase stepping, attack cooldown and sprite
// address generation. Define ENEMY_DIAGONAL_EN to step X and Y on the same tick.
module enemy_chaser
   import enemy_pkg::*;
#(
   parameter int ID          = 0,
   parameter int W           = 26,
   parameter int H           = 26,
   parameter int PW          = 18,
   parameter int PH          = 20,
   parameter int STEP        = 1,
   parameter int FRAME_DIV   = 4,
   parameter int MAX_HP      = 3,
   parameter int ATK_PERIOD  = 8,
   parameter int DEATH_TICKS = 6,
   parameter int X_MIN       = PF_X_MIN,
   parameter int X_MAX       = PF_X_MAX,
   parameter int Y_MIN       = PF_Y_MIN,
   parameter int Y_MAX       = PF_Y_MAX
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         frame_clk,
   enemy_chaser_if.slave bus
);
   localparam logic [8:0] SPAWN_X = 9'(70 * (ID + 1) - W / 2);
   localparam logic [8:0] SPAWN_Y = 9'(40 * (ID + 1) - H / 2);

   localparam logic [2:0] S_DEAD   = DEAD;
   localparam logic [2:0] S_SPAWN  = SPAWN;
   localparam logic [2:0] S_CHASE  = CHASE;
   localparam logic [2:0] S_ATTACK = ATTACK;
   localparam logic [2:0] S_DYING  = DYING;

   logic       tick;
   logic [2:0] state;
   logic [2:0] hp;
   logic [8:0] x, y;
   dir_t       dir;
   logic [1:0] anim;
   logic [7:0] phase_cnt;
   logic [7:0] cool;
   logic       strobe;

   enemy_tick_gen #(.FRAME_DIV(FRAME_DIV)) u_tick (
      .Clk       (Clk),
      .Reset     (Reset),
      .frame_clk (frame_clk),
      .tick      (tick)
   );

   logic [9:0] x10, y10, plx10, ply10;
   logic       go_r, go_l, go_d, go_u, adjacent;
   logic       mv_x_inc, mv_x_dec, mv_y_inc, mv_y_dec;
   dir_t       step_dir;
   logic [8:0] next_x, next_y;
   logic       kill;

   assign x10   = {1'b0, x};
   assign y10   = {1'b0, y};
   assign plx10 = {1'b0, bus.Player_X};
   assign ply10 = {1'b0, bus.Player_Y};

   // NOTE: every variable gets a default at the top so no path infers a latch.
   always_comb begin
      go_r     = (x10 + 10'(W)) < plx10;
      go_l     = x10 > (plx10 + 10'(PW));
      go_d     = (y10 + 10'(H)) < ply10;
      go_u     = y10 > (ply10 + 10'(PH));
      adjacent = !(go_r || go_l || go_d || go_u);
`ifdef ENEMY_DIAGONAL_EN
      mv_x_inc = go_r;
      mv_x_dec = go_l;
      mv_y_inc = go_d;
      mv_y_dec = go_u;
`else
      mv_x_inc = go_r;
      mv_x_dec = !go_r && go_l;
      mv_y_inc = !go_r && !go_l && go_d;
      mv_y_dec = !go_r && !go_l && !go_d && go_u;
`endif
      if (go_r)      step_dir = RIGHT;
      else if (go_l) step_dir = LEFT;
      else if (go_d) step_dir = DOWN;
      else           step_dir = UP;
      // Both axes are clamped even when only one moves, pulling an
      // off-field spawn point into the playfield on the first step.
      next_x = move_clamp(x, mv_x_inc, mv_x_dec, 9'(STEP), 9'(X_MIN), 9'(X_MAX));
      next_y = move_clamp(y, mv_y_inc, mv_y_dec, 9'(STEP), 9'(Y_MIN), 9'(Y_MAX));
   end

   // A hit at HP 1 ends the chase before any movement or strobe on this cycle.
   assign kill = bus.hit && (hp <= 3'd1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state     <= S_DEAD;
         hp        <= '0;
         x         <= SPAWN_X;
         y         <= SPAWN_Y;
         dir       <= DOWN;
         anim      <= '0;
         phase_cnt <= '0;
         cool      <= '0;
         strobe    <= 1'b0;
      end else begin
         strobe <= 1'b0;
         case (state)
            S_DEAD: begin
               if (bus.spawn_req) begin
                  x         <= SPAWN_X;
                  y         <= SPAWN_Y;
                  hp        <= 3'(MAX_HP);
                  phase_cnt <= '0;
                  state     <= S_SPAWN;
               end
            end
            S_SPAWN: begin
               if (tick) begin
                  if (phase_cnt == 8'd1) begin
                     phase_cnt <= '0;
                     state     <= S_CHASE;
                  end else begin
                     phase_cnt <= phase_cnt + 8'd1;
                  end
               end
            end
            S_CHASE, S_ATTACK: begin
               if (kill) begin
                  hp        <= '0;
                  phase_cnt <= '0;
                  state     <= S_DYING;
               end else begin
                  if (bus.hit)
                     hp <= hp - 3'd1;
                  if (tick) begin
                     if (state == S_CHASE) begin
                        if (adjacent) begin
                           cool  <= '0;
                           state <= S_ATTACK;
                        end else begin
                           x    <= next_x;
                           y    <= next_y;
                           dir  <= step_dir;
                           anim <= anim + 2'd1;
                        end
                     end else if (!adjacent) begin
                        state <= S_CHASE;
                     end else if (cool == 8'd0) begin
                        strobe <= 1'b1;
                        cool   <= 8'(ATK_PERIOD - 1);
                     end else begin
                        cool <= cool - 8'd1;
                     end
                  end
               end
            end
            S_DYING: begin
               if (tick) begin
                  if (phase_cnt == 8'(DEATH_TICKS - 1)) begin
                     phase_cnt <= '0;
                     state     <= S_DEAD;
                  end else begin
                     phase_cnt <= phase_cnt + 8'd1;
                  end
               end
            end
            default: state <= S_DEAD;
         endcase
      end
   end

   logic [9:0]  px10, py10;
   logic        visible;
   logic [1:0]  frame;
   logic [3:0]  sprite_idx;
   logic [12:0] dist_x, dist_y, addr;

   assign px10 = {1'b0, bus.PixelX};
   assign py10 = {1'b0, bus.PixelY};

   // Sprite sheet: three frames per facing, each W*H pixels, row-major.
   always_comb begin
      visible = (state != S_DEAD)
             && (px10 >= x10) && (px10 < x10 + 10'(W))
             && (py10 >= y10) && (py10 < y10 + 10'(H));
      frame = 2'd0;
      if (state != S_DYING && anim[0])
         frame = anim[1] ? 2'd2 : 2'd1;
      sprite_idx = {2'b00, dir} * 4'd3 + {2'b00, frame};
      dist_x     = {4'b0000, bus.PixelX} - {4'b0000, x};
      dist_y     = {4'b0000, bus.PixelY} - {4'b0000, y};
      addr       = dist_x + dist_y * 13'(W) + {9'b0, sprite_idx} * 13'(W * H);
      bus.is_obj      = visible;
      bus.Obj_address = visible ? addr : 13'd0;
   end

   assign bus.Obj_X_Pos     = x;
   assign bus.Obj_Y_Pos     = y;
   assign bus.Obj_Direction = dir;
   assign bus.Attack_Strobe = strobe;
   assign bus.is_alive      = (state == S_CHASE) || (state == S_ATTACK);

endmodule
